// File: rtl/amba_requester_pkg.sv
// Shared types and defaults for the APB requester and the completer-side blocks.
package amba_pkg;

    localparam int AMBA_ADDR_W  = 32;
    localparam int AMBA_DATA_W  = 32;
    localparam int AMBA_TIMEOUT = 16;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        SETUP  = 2'd1,
        ACCESS = 2'd2
    } apb_state_e;

    typedef struct packed {
        logic [AMBA_DATA_W-1:0] rdata;
        logic                   err;
        logic                   timeout;
    } apb_rsp_t;

    // Width of a counter that must be able to hold the value TIMEOUT.
    function automatic int wait_cnt_width(input int timeout);
        return $clog2(timeout + 1);
    endfunction

endpackage

// File: rtl/amba_requester_if.sv
// Command, response and APB bus signals of the requester, grouped for port passing.
interface amba_requester_if #(
    parameter int ADDR_W = amba_pkg::AMBA_ADDR_W,
    parameter int DATA_W = amba_pkg::AMBA_DATA_W
);
    logic              cmd_valid;
    logic              cmd_ready;
    logic              cmd_write;
    logic [ADDR_W-1:0] cmd_addr;
    logic [DATA_W-1:0] cmd_wdata;

    logic              rsp_valid;
    logic [DATA_W-1:0] rsp_rdata;
    logic              rsp_err;
    logic              rsp_timeout;

    logic [ADDR_W-1:0] PADDR;
    logic              PSEL;
    logic              PENABLE;
    logic              PWRITE;
    logic [DATA_W-1:0] PWDATA;
    logic [DATA_W-1:0] PRDATA;
    logic              PREADY;
    logic              PSLVERR;

    modport master (
        input  cmd_valid, cmd_write, cmd_addr, cmd_wdata,
        input  PRDATA, PREADY, PSLVERR,
        output cmd_ready, rsp_valid, rsp_rdata, rsp_err, rsp_timeout,
        output PADDR, PSEL, PENABLE, PWRITE, PWDATA
    );

    modport slave (
        output cmd_valid, cmd_write, cmd_addr, cmd_wdata,
        output PRDATA, PREADY, PSLVERR,
        input  cmd_ready, rsp_valid, rsp_rdata, rsp_err, rsp_timeout,
        input  PADDR, PSEL, PENABLE, PWRITE, PWDATA
    );
endinterface

// File: rtl/amba_requester_wait_timer.sv
// Consecutive-wait counter; o_expired flags that the current wait is the TIMEOUT-th one.
module amba_wait_timer
    import amba_pkg::*;
#(
    parameter int TIMEOUT = AMBA_TIMEOUT
) (
    input  logic clk,
    input  logic rst_n,
    input  logic i_clear,
    input  logic i_count_en,
    output logic o_expired
);
    localparam int                CNT_W = wait_cnt_width(TIMEOUT);
    localparam logic [CNT_W-1:0] LAST  = CNT_W'(TIMEOUT - 1);

    logic [CNT_W-1:0] r_count;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_count <= '0;
        end else if (i_clear) begin
            r_count <= '0;
        end else if (i_count_en) begin
            r_count <= r_count + 1'b1;
        end
    end

    // Expiry is not gated by the enable so the owner decides when it matters.
    assign o_expired = (r_count == LAST);

endmodule

// File: rtl/amba_requester.sv
// APB requester: runs one SETUP/ACCESS transfer per accepted command and reports it on a response strobe.
//   state  | meaning
//   IDLE   | bus idle, cmd_ready high
//   SETUP  | PSEL high, PENABLE low, address phase
//   ACCESS | PSEL and PENABLE high, waiting for PREADY or timeout
module amba_requester
    import amba_pkg::*;
#(
    parameter int ADDR_W  = AMBA_ADDR_W,
    parameter int DATA_W  = AMBA_DATA_W,
    parameter int TIMEOUT = AMBA_TIMEOUT
) (
    input  logic             PCLK,
    input  logic             PRESETn,
    amba_requester_if.master bus
);
    apb_state_e        r_state;
    apb_state_e        w_next_state;
    logic              w_accept;
    logic              w_complete;
    logic              w_abort;
    logic              w_count_en;
    logic              w_expired;

    logic [ADDR_W-1:0] r_paddr;
    logic              r_pwrite;
    logic [DATA_W-1:0] r_pwdata;
    logic              r_psel;
    logic              r_penable;
    logic              r_rsp_valid;
    logic [DATA_W-1:0] r_rsp_rdata;
    logic              r_rsp_err;
    logic              r_rsp_timeout;

    amba_wait_timer #(.TIMEOUT(TIMEOUT)) u_wait_timer (
        .clk        (PCLK),
        .rst_n      (PRESETn),
        .i_clear    (w_accept),
        .i_count_en (w_count_en),
        .o_expired  (w_expired)
    );

    always_ff @(posedge PCLK or negedge PRESETn) begin
        if (!PRESETn) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_next_state;
        end
    end

    always_comb begin
        w_next_state = r_state;
        w_accept     = 1'b0;
        w_complete   = 1'b0;
        w_abort      = 1'b0;
        w_count_en   = 1'b0;
        case (r_state)
            IDLE: begin
                if (bus.cmd_valid) begin
                    w_accept     = 1'b1;
                    w_next_state = SETUP;
                end
            end
            SETUP: begin
                w_next_state = ACCESS;
            end
            ACCESS: begin
                if (bus.PREADY) begin
                    w_complete   = 1'b1;
                    w_next_state = IDLE;
                end else begin
                    w_count_en = 1'b1;
                    if (w_expired) begin
                        w_abort      = 1'b1;
                        w_next_state = IDLE;
                    end
                end
            end
            default: begin
                w_next_state = IDLE;
            end
        endcase
    end

    // Bus strobes are registered from the next state so they line up with the state register.
    always_ff @(posedge PCLK or negedge PRESETn) begin
        if (!PRESETn) begin
            r_paddr       <= '0;
            r_pwrite      <= 1'b0;
            r_pwdata      <= '0;
            r_psel        <= 1'b0;
            r_penable     <= 1'b0;
            r_rsp_valid   <= 1'b0;
            r_rsp_rdata   <= '0;
            r_rsp_err     <= 1'b0;
            r_rsp_timeout <= 1'b0;
        end else begin
            if (w_accept) begin
                r_paddr  <= bus.cmd_addr;
                r_pwrite <= bus.cmd_write;
                r_pwdata <= bus.cmd_wdata;
            end
            r_psel      <= (w_next_state != IDLE);
            r_penable   <= (w_next_state == ACCESS);
            r_rsp_valid <= w_complete | w_abort;
            if (w_complete) begin
                r_rsp_rdata   <= r_pwrite ? '0 : bus.PRDATA;
                r_rsp_err     <= bus.PSLVERR;
                r_rsp_timeout <= 1'b0;
            end else if (w_abort) begin
                r_rsp_rdata   <= '0;
                r_rsp_err     <= 1'b1;
                r_rsp_timeout <= 1'b1;
            end
        end
    end

    assign bus.cmd_ready   = (r_state == IDLE);
    assign bus.PADDR       = r_paddr;
    assign bus.PWRITE      = r_pwrite;
    assign bus.PWDATA      = r_pwdata;
    assign bus.PSEL        = r_psel;
    assign bus.PENABLE     = r_penable;
    assign bus.rsp_valid   = r_rsp_valid;
    assign bus.rsp_rdata   = r_rsp_rdata;
    assign bus.rsp_err     = r_rsp_err;
    assign bus.rsp_timeout = r_rsp_timeout;

endmodule
